// File: rtl/probe_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : probe_conditioner_pkg
//  Description : Shared constants and helpers for the probe conditioner.
//                filt_cnt_width() sizes the per-channel glitch-filter counter.
//                params_ok() validates the top-level parameter set so a bad
//                configuration fails at elaboration.
//  Revision    : 1.0  initial release
// ============================================================================
package probe_conditioner_pkg;

    localparam int unsigned MAX_PROBES         = 64;
    localparam int unsigned MIN_SYNC_STAGES    = 2;
    localparam int unsigned MAX_SYNC_STAGES    = 4;
    localparam int unsigned MIN_FILTER_CYCLES  = 1;
    localparam int unsigned MAX_FILTER_CYCLES  = 255;
    localparam int unsigned MIN_WINDOW_EXP     = 4;
    localparam int unsigned MAX_WINDOW_EXP     = 30;

    // The counter must be able to hold FILTER_CYCLES-1.
    // clog2(F+1) covers that and is never below 1.
    function automatic int unsigned filt_cnt_width(input int unsigned filter_cycles);
        int unsigned w;
        w = $clog2(filter_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int unsigned n_probe,
                                     input int unsigned sync_stages,
                                     input int unsigned filter_cycles,
                                     input int unsigned window_exp);
        return (n_probe >= 1) && (n_probe <= MAX_PROBES) &&
               (sync_stages >= MIN_SYNC_STAGES) && (sync_stages <= MAX_SYNC_STAGES) &&
               (filter_cycles >= MIN_FILTER_CYCLES) && (filter_cycles <= MAX_FILTER_CYCLES) &&
               (window_exp >= MIN_WINDOW_EXP) && (window_exp <= MAX_WINDOW_EXP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/probe_filter_channel.sv
`default_nettype none
// ============================================================================
//  Module      : probe_filter_channel
//  Description : One probe channel: synchroniser chain, glitch filter,
//                conditioned level / edge flops and sticky activity flag.
//  Ports       : i_clk        system clock
//                i_rst_n      async active-low reset
//                i_cg         clock-gate enable (0 = hold all state)
//                i_bypass     1 = filter length forced to one cycle
//                i_pin        raw asynchronous probe pin
//                i_window_end high on the last cycle of an activity window
//                o_probe      conditioned level
//                o_edge       one-cycle pulse on accepted level change
//                o_active     edge seen in the last completed window
//  Revision    : 1.0  initial release
// ============================================================================
module probe_filter_channel
    import probe_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int CNT_W         = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cg,
    input  logic i_bypass,
    input  logic i_pin,
    input  logic i_window_end,
    output logic o_probe,
    output logic o_edge,
    output logic o_active
);

    localparam logic [CNT_W-1:0] C_THRESH_FILT = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_probe;
    logic                   r_edge;
    logic                   r_acc;
    logic                   r_active;

    logic [CNT_W-1:0]       w_thresh;
    logic                   w_sync;
    logic                   w_differs;
    logic                   w_accept;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_thresh  = i_bypass ? '0 : C_THRESH_FILT;
    assign w_differs = (w_sync != r_probe);
    // ">=" rather than "==" so that switching into bypass with a count already
    // running accepts the pending change on that very edge.
    assign w_accept  = w_differs && (r_cnt >= w_thresh);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_probe  <= 1'b0;
            r_edge   <= 1'b0;
            r_acc    <= 1'b0;
            r_active <= 1'b0;
        end else if (i_cg) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_edge <= w_accept;

            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_probe <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end

            // An edge on the window's last cycle belongs to the closing window.
            if (i_window_end) begin
                r_active <= r_acc | w_accept;
                r_acc    <= 1'b0;
            end else begin
                r_acc <= r_acc | w_accept;
            end
        end
    end

    assign o_probe  = r_probe;
    assign o_edge   = r_edge;
    assign o_active = r_active;

endmodule
`default_nettype wire

// File: rtl/probe_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : probe_conditioner
//  Description : Conditions N_PROBE asynchronous probe pins for the
//                correlator: synchronise, reject glitches, emit edge pulses
//                and per-window sticky activity flags.
//  Ports       : i_clk          48MHz system clock
//                i_rst_n        async active-low reset
//                i_cg           clock-gate enable (0 = hold all state)
//                i_bypass       1 = no glitch filtering
//                i_pin_probe    raw probe pins [N_PROBE]
//                o_probe        conditioned levels [N_PROBE]
//                o_edge         accepted-change pulses [N_PROBE]
//                o_active       activity in last completed window [N_PROBE]
//                o_windowStrobe pulse when o_active updates
//  Revision    : 1.0  initial release
// ============================================================================
module probe_conditioner
    import probe_conditioner_pkg::*;
#(
    parameter int N_PROBE             = 64,
    parameter int SYNC_STAGES         = 2,
    parameter int FILTER_CYCLES       = 3,
    parameter int ACTIVITY_WINDOW_EXP = 22
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cg,
    input  logic               i_bypass,
    input  logic [N_PROBE-1:0] i_pin_probe,
    output logic [N_PROBE-1:0] o_probe,
    output logic [N_PROBE-1:0] o_edge,
    output logic [N_PROBE-1:0] o_active,
    output logic               o_windowStrobe
);

    localparam int CNT_W = int'(filt_cnt_width(FILTER_CYCLES));
    localparam logic [ACTIVITY_WINDOW_EXP-1:0] C_WCNT_ONE = ACTIVITY_WINDOW_EXP'(1);

    if (!params_ok(N_PROBE, SYNC_STAGES, FILTER_CYCLES, ACTIVITY_WINDOW_EXP)) begin : g_param_check
        $error("probe_conditioner: parameter out of range");
    end

    logic [ACTIVITY_WINDOW_EXP-1:0] r_wcnt;
    logic                           r_strobe;
    logic                           w_window_end;

    assign w_window_end = &r_wcnt;

    // Free-running window counter; wraps naturally from all-ones to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wcnt   <= '0;
            r_strobe <= 1'b0;
        end else if (i_cg) begin
            r_wcnt   <= r_wcnt + C_WCNT_ONE;
            r_strobe <= w_window_end;
        end
    end

    assign o_windowStrobe = r_strobe;

    for (genvar g = 0; g < N_PROBE; g++) begin : g_channel
        probe_filter_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_cg         (i_cg),
            .i_bypass     (i_bypass),
            .i_pin        (i_pin_probe[g]),
            .i_window_end (w_window_end),
            .o_probe      (o_probe[g]),
            .o_edge       (o_edge[g]),
            .o_active     (o_active[g])
        );
    end

endmodule
`default_nettype wire
